// File: rtl/video_pattern_source_if.sv
// video_pattern_source_if: AXI4-Stream video beat bundle between the pattern source and scanout
interface video_pattern_source_if;
    logic [31:0] m_axis_vid_tdata;
    logic        m_axis_vid_tlast;
    logic [0:0]  m_axis_vid_tuser;
    logic        m_axis_vid_tvalid;
    logic        m_axis_vid_tready;

    modport master (
        output m_axis_vid_tdata, m_axis_vid_tlast, m_axis_vid_tuser, m_axis_vid_tvalid,
        input  m_axis_vid_tready
    );

    modport slave (
        input  m_axis_vid_tdata, m_axis_vid_tlast, m_axis_vid_tuser, m_axis_vid_tvalid,
        output m_axis_vid_tready
    );
endinterface

// File: rtl/video_pattern_source.sv
// video_pattern_source: synthesizes test-pattern video frames on an AXI4-Stream in VDMA beat format
module video_pattern_source #(
    parameter int GAP_CYCLES = 16,
    parameter int CHECK_BIT  = 4
) (
    input  logic                   m_axis_vid_aclk,
    input  logic                   aresetn,
    input  logic [31:0]            control_data,
    input  logic [7:0]             control_op,
    video_pattern_source_if.master vid,
    output logic [7:0]             frame_count
);
    localparam logic [7:0] OP_COLORMODE  = 8'd1;
    localparam logic [7:0] OP_DIMENSIONS = 8'd2;
    localparam logic [7:0] OP_SCALE      = 8'd4;
    localparam logic [7:0] OP_PATTERN    = 8'd10;
    localparam logic [7:0] OP_SOLID      = 8'd11;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    logic [7:0]  op_q;
    logic [31:0] data_q;
    logic [15:0] width_q, height_q;
    logic [1:0]  colormode_q, pattern_q;
    logic        scale_x_q, enable_q;
    logic [23:0] solid_q;

    state_t      state_q;
    logic [15:0] sh_words_q, sh_lines_q;
    logic [1:0]  sh_pattern_q;
    logic [23:0] sh_solid_q;
    logic [15:0] x_q, y_q, gap_q;
    logic [7:0]  frame_count_q;
    logic [31:0] tdata_q;
    logic        tlast_q, tuser_q, tvalid_q;

    logic [15:0] live_words, x_d, y_d;
    logic        last_x, frame_end, gap_done, start;

    // Words per line: pixels packed per 32-bit word depend on colormode, then halved when scaling
    function automatic logic [15:0] words_of(input logic [15:0] w, input logic [1:0] cm, input logic sx);
        return ((cm == 2'd0) ? (w >> 2) : (cm == 2'd1) ? (w >> 1) : w) >> sx;
    endfunction

    function automatic logic [31:0] pixel(input logic [1:0] pat, input logic [23:0] sol,
                                          input logic [11:0] px, input logic [11:0] py, input logic [7:0] f);
        return (pat == 2'd0) ? {8'h00, sol}
             : (pat == 2'd1) ? {8'h00, px[7:0], px[7:0], px[7:0]}
             : (pat == 2'd2) ? ((px[CHECK_BIT] ^ py[CHECK_BIT]) ? 32'h00FF_FFFF : 32'h0000_0000)
             : {f, py, px};
    endfunction

    // Next beat position and frame-start decision
    always_comb begin
        live_words = words_of(width_q, colormode_q, scale_x_q);
        last_x     = x_q == sh_words_q - 16'd1;
        x_d        = last_x ? 16'd0 : x_q + 16'd1;
        y_d        = last_x ? y_q + 16'd1 : y_q;
        frame_end  = last_x && (y_q == sh_lines_q - 16'd1);
        gap_done   = (state_q == GAP) && (gap_q == 16'(GAP_CYCLES - 1));
        start      = ((state_q == IDLE) || gap_done) && enable_q && (live_words != 16'd0) && (height_q != 16'd0);
    end

    // Control bus: register the level-held op once, then decode into the live config
    always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
        if (!aresetn) begin
            op_q        <= 8'd0;
            data_q      <= 32'd0;
            width_q     <= 16'd1280;
            height_q    <= 16'd720;
            colormode_q <= 2'd2;
            scale_x_q   <= 1'b0;
            pattern_q   <= 2'd0;
            enable_q    <= 1'b0;
            solid_q     <= 24'd0;
        end else begin
            op_q   <= control_op;
            data_q <= control_data;
            case (op_q)
                OP_COLORMODE:  colormode_q <= data_q[1:0];
                OP_DIMENSIONS: begin
                    height_q <= data_q[31:16];
                    width_q  <= data_q[15:0];
                end
                OP_SCALE:      scale_x_q <= data_q[0];
                OP_PATTERN:    begin
                    pattern_q <= data_q[1:0];
                    enable_q  <= data_q[8];
                end
                OP_SOLID:      solid_q <= data_q[23:0];
                default:       ;
            endcase
        end
    end

    // Frame FSM: shadows config at each frame start and precomputes the next beat into the output registers
    always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            sh_words_q    <= 16'd0;
            sh_lines_q    <= 16'd0;
            sh_pattern_q  <= 2'd0;
            sh_solid_q    <= 24'd0;
            x_q           <= 16'd0;
            y_q           <= 16'd0;
            gap_q         <= 16'd0;
            frame_count_q <= 8'd0;
            tdata_q       <= 32'd0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            tvalid_q      <= 1'b0;
        end else if (start) begin
            state_q      <= ACTIVE;
            sh_words_q   <= live_words;
            sh_lines_q   <= height_q;
            sh_pattern_q <= pattern_q;
            sh_solid_q   <= solid_q;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            tvalid_q     <= 1'b1;
            tuser_q      <= 1'b1;
            tlast_q      <= live_words == 16'd1;
            tdata_q      <= pixel(pattern_q, solid_q, 12'd0, 12'd0, frame_count_q);
        end else if (state_q == ACTIVE && tvalid_q && vid.m_axis_vid_tready) begin
            tuser_q <= 1'b0;
            if (frame_end) begin
                state_q       <= GAP;
                gap_q         <= 16'd0;
                frame_count_q <= frame_count_q + 8'd1;
                tvalid_q      <= 1'b0;
                tlast_q       <= 1'b0;
                tdata_q       <= 32'd0;
            end else begin
                x_q     <= x_d;
                y_q     <= y_d;
                tlast_q <= x_d == sh_words_q - 16'd1;
                tdata_q <= pixel(sh_pattern_q, sh_solid_q, x_d[11:0], y_d[11:0], frame_count_q);
            end
        end else if (state_q == GAP) begin
            state_q <= gap_done ? IDLE : GAP;
            gap_q   <= gap_q + 16'd1;
        end
    end

    assign vid.m_axis_vid_tdata  = tdata_q;
    assign vid.m_axis_vid_tlast  = tlast_q;
    assign vid.m_axis_vid_tuser  = tuser_q;
    assign vid.m_axis_vid_tvalid = tvalid_q;
    assign frame_count           = frame_count_q;
endmodule

// File: tb/tb_video_pattern_source.sv
// tb_video_pattern_source: scoreboard bench for the test-pattern video source
module tb_video_pattern_source;
    localparam int GAP = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] control_data = 32'd0;
    logic [7:0]  control_op = 8'd0;
    logic [7:0]  frame_count;

    video_pattern_source_if vid();

    video_pattern_source #(.GAP_CYCLES(GAP), .CHECK_BIT(4)) dut (
        .m_axis_vid_aclk(clk),
        .aresetn(aresetn),
        .control_data(control_data),
        .control_op(control_op),
        .vid(vid),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_fc = 0;
    int    gap_run = 0;
    int    sof_gap = -1;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;

    // Monitor: pops the scoreboard on each handshake, checks stall stability, measures the gap before each frame
    always @(negedge clk) begin : monitor
        beat_t cur, e;
        cur = {vid.m_axis_vid_tdata, vid.m_axis_vid_tuser[0], vid.m_axis_vid_tlast};
        if (!aresetn) begin
            prev_stall = 1'b0;
            gap_run = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (vid.m_axis_vid_tvalid !== 1'b1 || cur !== prev_beat) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h user=%b last=%b, required valid=1 data=%h user=%b last=%b",
                             vid.m_axis_vid_tvalid, cur.data, cur.user, cur.last, prev_beat.data, prev_beat.user, prev_beat.last);
                end
            end
            if (vid.m_axis_vid_tvalid === 1'b1) begin
                if (cur.user && gap_run != 0) sof_gap = gap_run;
                gap_run = 0;
            end else gap_run++;
            if (vid.m_axis_vid_tvalid === 1'b1 && vid.m_axis_vid_tready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h user=%b last=%b, required no beat", cur.data, cur.user, cur.last);
                end else begin
                    e = q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL beat: got data=%h user=%b last=%b, required data=%h user=%b last=%b (remaining %0d)",
                                 cur.data, cur.user, cur.last, e.data, e.user, e.last, q.size());
                    end
                end
            end
            prev_stall = (vid.m_axis_vid_tvalid === 1'b1) && (vid.m_axis_vid_tready !== 1'b1);
            prev_beat = cur;
        end
    end

    task automatic push_frame(input int words, input int lines, input logic [1:0] pat, input logic [23:0] solid);
        logic [11:0] xs, ys;
        logic [7:0]  f;
        beat_t       b;
        f = 8'(exp_fc);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < words; x++) begin
                xs = 12'(x);
                ys = 12'(y);
                case (pat)
                    2'd0:    b.data = {8'h00, solid};
                    2'd1:    b.data = {8'h00, xs[7:0], xs[7:0], xs[7:0]};
                    2'd2:    b.data = (xs[4] ^ ys[4]) ? 32'h00FF_FFFF : 32'h0;
                    default: b.data = {f, ys, xs};
                endcase
                b.user = (x == 0 && y == 0);
                b.last = (x == words - 1);
                q.push_back(b);
            end
        end
        exp_fc++;
    endtask

    task automatic send_op(input logic [7:0] op, input logic [31:0] d);
        control_op = op;
        control_data = d;
        repeat (3) @(posedge clk);
        #1;
        control_op = 8'd0;
    endtask

    task automatic wait_q_below(input int n, input bit rnd, input string what);
        int cyc = 0;
        while (q.size() >= n && cyc < 20000) begin
            @(posedge clk);
            #1;
            if (rnd) vid.m_axis_vid_tready = 1'($urandom_range(0, 1));
            cyc++;
        end
        checks++;
        if (q.size() >= n) begin
            errors++;
            $display("FAIL %s_timeout: queue depth %0d, required below %0d", what, q.size(), n);
        end
    endtask

    task automatic finish_stream(input bit rnd, input string what);
        wait_q_below(1, rnd, what);
        vid.m_axis_vid_tready = 1'b1;
        q.delete();
        repeat (GAP + 8) @(posedge clk);
        #1;
        checks++;
        if (vid.m_axis_vid_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got tvalid=%b, required 0", what, vid.m_axis_vid_tvalid);
        end
        checks++;
        if (frame_count !== 8'(exp_fc)) begin
            errors++;
            $display("FAIL %s_frame_count: got %0d, required %0d", what, frame_count, exp_fc);
        end
    endtask

    task automatic test_reset();
        vid.m_axis_vid_tready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (vid.m_axis_vid_tvalid !== 1'b0 || vid.m_axis_vid_tdata !== 32'd0 ||
            vid.m_axis_vid_tuser !== 1'b0 || vid.m_axis_vid_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h user=%b last=%b, required all 0",
                     vid.m_axis_vid_tvalid, vid.m_axis_vid_tdata, vid.m_axis_vid_tuser, vid.m_axis_vid_tlast);
        end
        checks++;
        if (frame_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_frame_count: got %0d, required 0", frame_count);
        end
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        vid.m_axis_vid_tready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (vid.m_axis_vid_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_disabled: got tvalid=%b, required 0", vid.m_axis_vid_tvalid);
        end
    endtask

    task automatic test_main();
        send_op(8'd2, 32'h0004_0040);
        push_frame(64, 4, 2'd3, 24'd0);
        push_frame(64, 4, 2'd3, 24'd0);
        vid.m_axis_vid_tready = 1'b1;
        send_op(8'd10, 32'h0000_0103);
        wait_q_below(256, 1'b0, "main_f0");
        checks++;
        if (sof_gap !== GAP) begin
            errors++;
            $display("FAIL main_gap: got %0d idle cycles, required %0d", sof_gap, GAP);
        end
        send_op(8'd10, 32'h0000_0003);
        finish_stream(1'b0, "main_f1");
    endtask

    task automatic test_geometry();
        send_op(8'd1, 32'd0);
        send_op(8'd4, 32'd1);
        send_op(8'd2, 32'h0002_0500);
        push_frame(160, 2, 2'd1, 24'd0);
        send_op(8'd10, 32'h0000_0101);
        wait_q_below(320, 1'b0, "geom_cm0");
        send_op(8'd10, 32'h0000_0001);
        finish_stream(1'b0, "geom_cm0");
        send_op(8'd1, 32'd1);
        send_op(8'd4, 32'd0);
        push_frame(640, 2, 2'd1, 24'd0);
        send_op(8'd10, 32'h0000_0101);
        wait_q_below(1280, 1'b0, "geom_cm1");
        send_op(8'd10, 32'h0000_0001);
        finish_stream(1'b0, "geom_cm1");
    endtask

    task automatic test_random_ready();
        send_op(8'd1, 32'd2);
        send_op(8'd2, 32'h0002_0500);
        push_frame(1280, 2, 2'd1, 24'd0);
        send_op(8'd10, 32'h0000_0101);
        wait_q_below(2560, 1'b1, "rand_start");
        send_op(8'd10, 32'h0000_0001);
        finish_stream(1'b1, "rand");
    endtask

    task automatic test_dims_midframe();
        send_op(8'd2, 32'h0008_0040);
        push_frame(64, 8, 2'd3, 24'd0);
        push_frame(32, 4, 2'd3, 24'd0);
        vid.m_axis_vid_tready = 1'b1;
        send_op(8'd10, 32'h0000_0103);
        wait_q_below(540, 1'b0, "dims_f0");
        send_op(8'd2, 32'h0004_0020);
        wait_q_below(128, 1'b0, "dims_f1");
        send_op(8'd10, 32'h0000_0003);
        finish_stream(1'b0, "dims");
    endtask

    task automatic test_checker();
        send_op(8'd2, 32'h0020_0040);
        push_frame(64, 32, 2'd2, 24'd0);
        send_op(8'd10, 32'h0000_0102);
        wait_q_below(2048, 1'b0, "checker_start");
        send_op(8'd10, 32'h0000_0002);
        finish_stream(1'b0, "checker");
    endtask

    task automatic test_reset_midline();
        send_op(8'd2, 32'h0002_0040);
        push_frame(64, 2, 2'd1, 24'd0);
        send_op(8'd10, 32'h0000_0101);
        wait_q_below(118, 1'b0, "rst_start");
        aresetn = 1'b0;
        #1;
        checks++;
        if (vid.m_axis_vid_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_valid: got tvalid=%b, required 0", vid.m_axis_vid_tvalid);
        end
        checks++;
        if (frame_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_frame_count: got %0d, required 0", frame_count);
        end
        q.delete();
        exp_fc = 0;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (vid.m_axis_vid_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_enable_cleared: got tvalid=%b, required 0", vid.m_axis_vid_tvalid);
        end
        send_op(8'd2, 32'h0002_0010);
        push_frame(16, 2, 2'd0, 24'd0);
        send_op(8'd10, 32'h0000_0100);
        wait_q_below(32, 1'b0, "rst_restart");
        send_op(8'd10, 32'h0000_0000);
        finish_stream(1'b0, "rst_restart");
    endtask

    initial begin
        vid.m_axis_vid_tready = 1'b0;
        test_reset();
        test_main();
        test_geometry();
        test_random_ready();
        test_dims_midframe();
        test_checker();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
